// File: rtl/cpu_defs.sv
// Shared definitions for the basic 16-bit CPU datapath.
//   - opcode constants decoded by the control unit
//   - ALU operation codes (shared with the ALU)
//   - control-unit timestep encodings and instruction field layout
package cpu_defs;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  localparam logic [1:0] ALU_NOP = 2'b00;
  localparam logic [1:0] ALU_ADD = 2'b01;
  localparam logic [1:0] ALU_SUB = 2'b10;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } tstep_t;

  // din[8:0] = {opcode, Rx, Ry}
  typedef struct packed {
    logic [2:0] op;
    logic [2:0] rx;
    logic [2:0] ry;
  } instr_t;

endpackage

// File: rtl/dec3to8.sv
// 3-to-8 one-hot decoder with enable.
//   i_en     : when 0 the output is all zeros
//   i_idx    : index to decode
//   o_onehot : 1 << i_idx when enabled
module dec3to8 (
  input  logic       i_en,
  input  logic [2:0] i_idx,
  output logic [7:0] o_onehot
);

  always_comb begin
    o_onehot = '0;
    if (i_en) o_onehot[i_idx] = 1'b1;
  end

endmodule

// File: rtl/control_unit.sv
// Instruction sequencer for the basic 16-bit CPU datapath.
// Latches a 9-bit instruction in T0 (when run=1), steps T0..T3 and drives
// the datapath control points combinationally from {timestep, IR, run}.
//   clk, resetn : clock, async active-low reset
//   run         : start request, only looked at in T0
//   din         : instruction source (din[8:0]) in T0
//   ir_in       : IR load strobe
//   r_in/r_out  : one-hot register write enable / bus drive select
//   din_out     : din drives the bus
//   g_out       : G drives the bus
//   a_in, g_in  : A / G register loads
//   alu_op      : ALU operation (NOP/ADD/SUB)
//   done        : last step of the current instruction
module control_unit
  import cpu_defs::*;
#(
  parameter int word = 16
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            run,
  input  logic [word-1:0] din,
  output logic            ir_in,
  output logic [7:0]      r_in,
  output logic [7:0]      r_out,
  output logic            din_out,
  output logic            g_out,
  output logic            a_in,
  output logic            g_in,
  output logic [1:0]      alu_op,
  output logic            done
);

  tstep_t     r_ts;
  tstep_t     w_ts_nxt;
  instr_t     r_ir;
  logic       w_arith;
  logic       w_rin_en;
  logic       w_rout_en;
  logic [2:0] w_rout_idx;
  logic       w_unused_din;

  // Only the low 9 bits carry an instruction; the rest is bus width only.
  assign w_unused_din = ^din[word-1:9];

  assign w_arith = (r_ir.op == OP_ADD) || (r_ir.op == OP_SUB);

  // State register: timestep + IR.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ts <= T0;
      r_ir <= '0;
    end else begin
      r_ts <= w_ts_nxt;
      if (r_ts == T0 && run) r_ir <= din[8:0];
    end
  end

  // Next timestep. T2/T3 with a non-arithmetic opcode cannot happen, but
  // falls back to T0 so the sequencer can never wedge.
  always_comb begin
    w_ts_nxt = T0;
    unique case (r_ts)
      T0: w_ts_nxt = run ? T1 : T0;
      T1: w_ts_nxt = w_arith ? T2 : T0;
      T2: w_ts_nxt = w_arith ? T3 : T0;
      T3: w_ts_nxt = T0;
    endcase
  end

  // Control outputs. r_in always writes Rx; r_out selects Rx or Ry.
  always_comb begin
    ir_in      = 1'b0;
    w_rin_en   = 1'b0;
    w_rout_en  = 1'b0;
    w_rout_idx = r_ir.ry;
    din_out    = 1'b0;
    g_out      = 1'b0;
    a_in       = 1'b0;
    g_in       = 1'b0;
    alu_op     = ALU_NOP;
    done       = 1'b0;
    unique case (r_ts)
      T0: ir_in = run;
      T1: begin
        case (r_ir.op)
          OP_MV: begin
            w_rout_en = 1'b1;
            w_rin_en  = 1'b1;
            done      = 1'b1;
          end
          OP_MVI: begin
            din_out  = 1'b1;
            w_rin_en = 1'b1;
            done     = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            w_rout_en  = 1'b1;
            w_rout_idx = r_ir.rx;
            a_in       = 1'b1;
          end
          default: done = 1'b1; // reserved opcodes retire as NOP
        endcase
      end
      T2: if (w_arith) begin
        w_rout_en = 1'b1;
        g_in      = 1'b1;
        alu_op    = (r_ir.op == OP_ADD) ? ALU_ADD : ALU_SUB;
      end
      T3: if (w_arith) begin
        g_out    = 1'b1;
        w_rin_en = 1'b1;
        done     = 1'b1;
      end
    endcase
  end

  dec3to8 u_dec_rin (
    .i_en     (w_rin_en),
    .i_idx    (r_ir.rx),
    .o_onehot (r_in)
  );

  dec3to8 u_dec_rout (
    .i_en     (w_rout_en),
    .i_idx    (w_rout_idx),
    .o_onehot (r_out)
  );

endmodule
